// File: rtl/scalar_operand_fetch.sv
// Scalar operand fetch: sequences one decoded instruction at a time through the
// 8x16 scalar register file, hides the file's registered read and old-data
// read-during-write behaviour, and tracks outstanding writes in a busy scoreboard.
// Also owns the file's write port, which is a straight pass-through of writeback.
module scalar_operand_fetch #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int NREG   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_srcA,
    input  logic [ADDR_W-1:0] req_srcB,
    input  logic [ADDR_W-1:0] req_dst,
    input  logic              req_dst_en,
    output logic [ADDR_W-1:0] SreadA,
    output logic [ADDR_W-1:0] SreadB,
    input  logic [DATA_W-1:0] Sa,
    input  logic [DATA_W-1:0] Sb,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              Swren,
    output logic [ADDR_W-1:0] Swraddr,
    output logic [DATA_W-1:0] Swrdata,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [ADDR_W-1:0] op_dst,
    output logic              op_dst_en,
    output logic [NREG-1:0]   sb_busy
);

    typedef enum logic [1:0] {IDLE, CHECK, FETCH, OUT} state_t;

    state_t            state;
    logic [ADDR_W-1:0] src_a;
    logic [ADDR_W-1:0] src_b;
    logic [ADDR_W-1:0] dst;
    logic              dst_en;
    logic              fwd_a;
    logic              fwd_b;
    logic [DATA_W-1:0] fwd_data_a;
    logic [DATA_W-1:0] fwd_data_b;
    logic              hit_a;
    logic              hit_b;
    logic              haz_a;
    logic              haz_b;
    logic [NREG-1:0]   sb_next;

    // The write port is never gated, not even by reset.
    assign Swren   = wb_valid;
    assign Swraddr = wb_addr;
    assign Swrdata = wb_data;

    // Read addresses come straight from the latched sources so the file sees
    // them during CHECK and returns data in FETCH.
    assign SreadA    = src_a;
    assign SreadB    = src_b;
    assign req_ready = (state == IDLE);

    // A writeback landing on a source this cycle both satisfies the hazard and
    // must be forwarded, since the file returns the pre-write value.
    assign hit_a = wb_valid && (wb_addr == src_a);
    assign hit_b = wb_valid && (wb_addr == src_b);
    assign haz_a = sb_busy[src_a] && !hit_a;
    assign haz_b = sb_busy[src_b] && !hit_b;

    // Scoreboard update: writeback clears first, a FETCH-cycle set overrides it.
    always_comb begin
        sb_next = sb_busy;
        if (wb_valid) begin
            sb_next[wb_addr] = 1'b0;
        end
        if ((state == FETCH) && dst_en) begin
            sb_next[dst] = 1'b1;
        end
    end

    // Instruction sequencer with registered operand outputs and scoreboard.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            src_a      <= '0;
            src_b      <= '0;
            dst        <= '0;
            dst_en     <= 1'b0;
            fwd_a      <= 1'b0;
            fwd_b      <= 1'b0;
            fwd_data_a <= '0;
            fwd_data_b <= '0;
            op_valid   <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
            op_dst     <= '0;
            op_dst_en  <= 1'b0;
            sb_busy    <= '0;
        end else begin
            sb_busy <= sb_next;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        src_a  <= req_srcA;
                        src_b  <= req_srcB;
                        dst    <= req_dst;
                        dst_en <= req_dst_en;
                        state  <= CHECK;
                    end
                end
                CHECK: begin
                    if (!(haz_a || haz_b)) begin
                        fwd_a      <= hit_a;
                        fwd_b      <= hit_b;
                        fwd_data_a <= wb_data;
                        fwd_data_b <= wb_data;
                        state      <= FETCH;
                    end
                end
                FETCH: begin
                    op_a      <= fwd_a ? fwd_data_a : Sa;
                    op_b      <= fwd_b ? fwd_data_b : Sb;
                    op_dst    <= dst;
                    op_dst_en <= dst_en;
                    op_valid  <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (op_ready) begin
                        op_valid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scalar_operand_fetch.sv
// Bench for scalar_operand_fetch: a register-file model with registered,
// old-data reads hangs off the DUT's read/write ports; a transaction-level
// model predicts outputs from architectural register values and busy rules.
module tb_scalar_operand_fetch;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_srcA;
    logic [2:0]  req_srcB;
    logic [2:0]  req_dst;
    logic        req_dst_en;
    logic [2:0]  SreadA;
    logic [2:0]  SreadB;
    logic [15:0] Sa;
    logic [15:0] Sb;
    logic        wb_valid;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        Swren;
    logic [2:0]  Swraddr;
    logic [15:0] Swrdata;
    logic        op_valid;
    logic        op_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [2:0]  op_dst;
    logic        op_dst_en;
    logic [7:0]  sb_busy;

    int n_checks = 0;
    int n_pass   = 0;

    scalar_operand_fetch #(.DATA_W(16), .ADDR_W(3), .NREG(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_srcA(req_srcA), .req_srcB(req_srcB),
        .req_dst(req_dst), .req_dst_en(req_dst_en),
        .SreadA(SreadA), .SreadB(SreadB), .Sa(Sa), .Sb(Sb),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .Swren(Swren), .Swraddr(Swraddr), .Swrdata(Swrdata),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b), .op_dst(op_dst), .op_dst_en(op_dst_en),
        .sb_busy(sb_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: registered read returning pre-write data, written by the DUT.
    logic [15:0] mem [8];
    always @(posedge clk) begin
        Sa <= mem[SreadA];
        Sb <= mem[SreadB];
        if (Swren) mem[Swraddr] <= Swrdata;
    end

    // Architectural register values, driven from the bench's own writeback stimulus.
    logic [15:0] arch [8];
    always @(posedge clk) begin
        if (wb_valid) arch[wb_addr] <= wb_data;
    end

    // Reference model: one instruction at a time.
    localparam int P_IDLE = 0, P_WAIT = 1, P_CAP = 2, P_SHOW = 3;
    int          m_phase;
    logic [7:0]  m_busy;
    logic [2:0]  m_sa, m_sb, m_dst;
    logic        m_en;
    logic [15:0] c_a, c_b;
    logic        e_valid;
    logic [15:0] e_a, e_b;
    logic [2:0]  e_dst;
    logic        e_dst_en;

    function automatic logic [7:0] busy_after(input logic [7:0] b, input logic wv,
                                              input logic [2:0] wa, input logic set,
                                              input logic [2:0] d);
        logic [7:0] r;
        r = b;
        if (wv) r[wa] = 1'b0;
        if (set) r[d] = 1'b1;
        return r;
    endfunction

    // Value register s holds once this cycle's writeback has landed.
    function automatic logic [15:0] value_after(input logic [2:0] s);
        if (wb_valid && wb_addr == s) return wb_data;
        return arch[s];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= P_IDLE; m_busy <= '0;
            m_sa <= '0; m_sb <= '0; m_dst <= '0; m_en <= 1'b0;
            c_a <= '0; c_b <= '0;
            e_valid <= 1'b0; e_a <= '0; e_b <= '0; e_dst <= '0; e_dst_en <= 1'b0;
        end else begin
            m_busy <= busy_after(m_busy, wb_valid, wb_addr, (m_phase == P_CAP) && m_en, m_dst);
            if (m_phase == P_IDLE && req_valid) begin
                m_sa <= req_srcA; m_sb <= req_srcB; m_dst <= req_dst; m_en <= req_dst_en;
                m_phase <= P_WAIT;
            end else if (m_phase == P_WAIT) begin
                if ((!m_busy[m_sa] || (wb_valid && wb_addr == m_sa)) &&
                    (!m_busy[m_sb] || (wb_valid && wb_addr == m_sb))) begin
                    c_a <= value_after(m_sa);
                    c_b <= value_after(m_sb);
                    m_phase <= P_CAP;
                end
            end else if (m_phase == P_CAP) begin
                e_a <= c_a; e_b <= c_b; e_dst <= m_dst; e_dst_en <= m_en;
                e_valid <= 1'b1;
                m_phase <= P_SHOW;
            end else if (m_phase == P_SHOW && op_ready) begin
                e_valid <= 1'b0;
                m_phase <= P_IDLE;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    // Cycle compare against the model on the falling edge.
    always @(negedge clk) begin
        check("req_ready", {31'd0, req_ready}, {31'd0, m_phase == P_IDLE});
        check("op_valid", {31'd0, op_valid}, {31'd0, e_valid});
        check("sb_busy", {24'd0, sb_busy}, {24'd0, m_busy});
        check("SreadA", {29'd0, SreadA}, {29'd0, m_sa});
        check("SreadB", {29'd0, SreadB}, {29'd0, m_sb});
        check("Swr", {12'd0, Swren, Swraddr, Swrdata}, {12'd0, wb_valid, wb_addr, wb_data});
        check("op_a", {16'd0, op_a}, {16'd0, e_a});
        check("op_b", {16'd0, op_b}, {16'd0, e_b});
        check("op_dst", {28'd0, op_dst_en, op_dst}, {28'd0, e_dst_en, e_dst});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [2:0] a, input logic [2:0] b,
                           input logic [2:0] d, input logic en);
        req_valid = 1'b1; req_srcA = a; req_srcB = b; req_dst = d; req_dst_en = en;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] preload [8];
        preload[0] = 16'h0000; preload[1] = 16'h1111; preload[2] = 16'h2222; preload[3] = 16'h3333;
        preload[4] = 16'h4444; preload[5] = 16'h5555; preload[6] = 16'h6666; preload[7] = 16'h7777;
        rst = 1'b1; req_valid = 1'b0; req_srcA = '0; req_srcB = '0; req_dst = '0;
        req_dst_en = 1'b0; wb_valid = 1'b0; wb_addr = '0; wb_data = '0; op_ready = 1'b0;
        // Preload the file through writeback while held in reset.
        for (int i = 0; i < 8; i++) begin
            wb_valid = 1'b1; wb_addr = 3'(i); wb_data = preload[i];
            tick();
        end
        wb_valid = 1'b0;
        tick();
        rst = 1'b0;
        check("reset_ready", {31'd0, req_ready}, 32'd1);
        check("reset_busy", {24'd0, sb_busy}, 32'd0);
        check("reset_opv", {31'd0, op_valid}, 32'd0);
        check("preload_r2", {16'd0, mem[2]}, 32'h2222);

        // Basic fetch: operands after two more edges.
        request(3'd1, 3'd2, 3'd3, 1'b1);
        tick();
        check("t1_early", {31'd0, op_valid}, 32'd0);
        tick();
        check("t1_opv", {31'd0, op_valid}, 32'd1);
        check("t1_a", {16'd0, op_a}, 32'h1111);
        check("t1_b", {16'd0, op_b}, 32'h2222);
        check("t1_dst", {29'd0, op_dst}, 32'd3);
        check("t1_busy", {24'd0, sb_busy}, 32'h08);
        op_ready = 1'b1; tick(); op_ready = 1'b0;

        // Hazard on busy r3 stalls until writeback, then forwards.
        request(3'd3, 3'd1, 3'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("t2_stall_v", {31'd0, op_valid}, 32'd0);
            check("t2_stall_r", {31'd0, req_ready}, 32'd0);
            tick();
        end
        wb_valid = 1'b1; wb_addr = 3'd3; wb_data = 16'hBEEF;
        tick();
        wb_valid = 1'b0;
        tick();
        check("t2_opv", {31'd0, op_valid}, 32'd1);
        check("t2_fwd_a", {16'd0, op_a}, 32'hBEEF);
        check("t2_b", {16'd0, op_b}, 32'h1111);
        check("t2_busy", {24'd0, sb_busy}, 32'h00);
        check("t2_file_r3", {16'd0, mem[3]}, 32'hBEEF);

        // Output holds under backpressure despite writebacks to the sources.
        for (int i = 0; i < 5; i++) begin
            wb_valid = 1'b1; wb_addr = (i % 2 == 0) ? 3'd3 : 3'd1; wb_data = 16'(16'hA000 + i);
            tick();
            check("t3_hold_a", {16'd0, op_a}, 32'hBEEF);
            check("t3_hold_b", {16'd0, op_b}, 32'h1111);
            check("t3_hold_v", {31'd0, op_valid}, 32'd1);
        end
        wb_valid = 1'b0; op_ready = 1'b1; tick(); op_ready = 1'b0;
        check("t3_ready", {31'd0, req_ready}, 32'd1);

        // Set wins over a same-cycle clear of the destination.
        request(3'd0, 3'd0, 3'd5, 1'b1);
        tick();
        wb_valid = 1'b1; wb_addr = 3'd5; wb_data = 16'h7777;
        tick();
        wb_valid = 1'b0;
        check("t4_setwins", {24'd0, sb_busy}, 32'h20);
        op_ready = 1'b1; tick(); op_ready = 1'b0;

        // Build busy=0x28, stall in CHECK, then asynchronous reset.
        request(3'd0, 3'd0, 3'd3, 1'b1);
        tick(); tick();
        op_ready = 1'b1; tick(); op_ready = 1'b0;
        check("t5_busy", {24'd0, sb_busy}, 32'h28);
        request(3'd5, 3'd0, 3'd1, 1'b1);
        tick();
        #2 rst = 1'b1;
        #1;
        check("t5_rst_busy", {24'd0, sb_busy}, 32'd0);
        check("t5_rst_ready", {31'd0, req_ready}, 32'd1);
        check("t5_rst_opv", {31'd0, op_valid}, 32'd0);
        tick();
        rst = 1'b0;

        // Randomized traffic checked cycle by cycle against the model.
        for (int c = 0; c < 1500; c++) begin
            req_valid  = ($urandom_range(0, 1) == 1);
            req_srcA   = 3'($urandom_range(0, 7));
            req_srcB   = 3'($urandom_range(0, 7));
            req_dst    = 3'($urandom_range(0, 7));
            req_dst_en = ($urandom_range(0, 3) != 0);
            wb_valid   = ($urandom_range(0, 9) < 4);
            wb_addr    = 3'($urandom_range(0, 7));
            wb_data    = 16'($urandom);
            op_ready   = ($urandom_range(0, 9) < 6);
            tick();
        end
        req_valid = 1'b0; wb_valid = 1'b0; op_ready = 1'b1;
        repeat (4) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/scalar_operand_fetch.md
Name: scalar_operand_fetch

Overview:
- Read-side client of the 8x16 scalar register file; also the single owner of the file's write port.
- Accepts decoded scalar instructions (srcA, srcB, optional dst) and drives SreadA/SreadB.
- Compensates for the file's one-cycle registered read and its old-data read-during-write behaviour.
- Keeps a per-register busy scoreboard for outstanding writes and forwards same-cycle writeback data.
- Sits between scalar decode and the scalar execute stage; execute results return through the wb_* port.

Parameters:
DATA_W, 16, scalar data width
ADDR_W, 3, register address width
NREG, 8, number of scalar registers (2**ADDR_W)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
req_valid  input  1  decode offers an instruction
req_ready  output  1  block can accept an instruction
req_srcA  input  ADDR_W  source A register
req_srcB  input  ADDR_W  source B register
req_dst  input  ADDR_W  destination register
req_dst_en  input  1  instruction will write req_dst
SreadA  output  ADDR_W  register-file read address A
SreadB  output  ADDR_W  register-file read address B
Sa  input  DATA_W  register-file read data A, valid one cycle after the address
Sb  input  DATA_W  register-file read data B
wb_valid  input  1  execute writeback strobe
wb_addr  input  ADDR_W  writeback register
wb_data  input  DATA_W  writeback data
Swren  output  1  register-file write enable
Swraddr  output  ADDR_W  register-file write address
Swrdata  output  DATA_W  register-file write data
op_valid  output  1  operands valid to execute
op_ready  input  1  execute accepts operands
op_a  output  DATA_W  operand A
op_b  output  DATA_W  operand B
op_dst  output  ADDR_W  destination passed through
op_dst_en  output  1  destination enable passed through
sb_busy  output  NREG  scoreboard busy vector

Behaviour:
- Write port: Swren=wb_valid, Swraddr=wb_addr, Swrdata=wb_data. Combinational pass-through, no gating, including while in reset.
- Reset state: state=IDLE, sb_busy=0, op_valid=0, op_a=op_b=0, op_dst=0, op_dst_en=0, latched src/dst regs=0. SreadA/SreadB come from the latched src regs, so they reset to 0.
- req_ready=1 only in IDLE. No other state accepts a request.
- FSM, one instruction in flight:
  - IDLE: on req_valid, latch srcA, srcB, dst, dst_en; go to CHECK.
  - CHECK: SreadA=srcA, SreadB=srcB. For each source X, hazX = sb_busy[srcX] && !(wb_valid && wb_addr==srcX).
    - If hazA or hazB: stay in CHECK.
    - Else go to FETCH. Set fwdX=1 and fwd_dataX=wb_data when wb_valid && wb_addr==srcX; otherwise fwdX=0.
  - FETCH: op_a = fwdA ? fwd_dataA : Sa; op_b = fwdB ? fwd_dataB : Sb. Register both with dst and dst_en. If dst_en, set sb_busy[dst]. Go to OUT.
  - OUT: op_valid=1; all op_* outputs held stable. On op_ready, go to IDLE.
- Latency: acceptance at edge E0 gives op_valid high after E2 with no hazard. Each hazard cycle adds one.
- Scoreboard:
  - wb_valid clears sb_busy[wb_addr] every cycle, in any state.
  - If the same register is cleared by wb and set by FETCH in one cycle, the set wins.
  - wb to a non-busy register still writes the file; the scoreboard is unchanged.
- srcA==srcB is legal; both operands take the same value. srcX==dst reads the old value; busy is set only after the read.
- Writebacks during FETCH/OUT do not alter the already captured operands.
- rst asserted mid-operation: abort immediately, drop op_valid, clear the scoreboard. Writebacks still reach the file.

Test Plan:
- Reset, then file preloaded r1=0x1111, r2=0x2222; request A=1, B=2, dst=3, dst_en=1 -> op_valid after E2, op_a=0x1111, op_b=0x2222, op_dst=3, sb_busy=0x08.
- With r3 busy, request A=3, B=1; hold wb idle for 4 cycles -> block stays in CHECK, op_valid=0, req_ready=0.
- Then wb_valid, wb_addr=3, wb_data=0xBEEF -> op_a=0xBEEF via forwarding, not the stale Sa; r3 written; sb_busy[3]=0.
- Hold op_ready=0 for 5 cycles in OUT while sending wb to the sources -> op_a/op_b unchanged, op_valid stays 1; op_ready=1 -> IDLE, req_ready=1.
- Request dst=5 while wb_addr=5 arrives in the FETCH cycle -> sb_busy[5]=1 (set wins).
- Assert rst while in CHECK with sb_busy=0x28 -> sb_busy=0, op_valid=0, state IDLE, req_ready=1 immediately (asynchronous).
